// File: rtl/timer_arbiter.sv
// Shared down-counting delay timer, granted round-robin to N requesters.
// A winner is picked in IDLE, its delay counts down on the tick strobe in RUN,
// and a one-cycle done pulse goes back to it in DONE. All outputs are flops.
module timer_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           tick,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dur,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   remaining
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] own_q, own_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          busy_q, busy_d;

  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic [W-1:0]  win_dur;
  logic [N-1:0]  own_onehot;

  // Round-robin search: first requester after the last winner, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_dur   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win_idx == IW'(i)) win_dur = dur[i*W +: W];
    end
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        rem_d = '0;
        if (win_valid) begin
          state_d = StRun;
          ptr_d   = win_idx;
          own_d   = win_idx;
          rem_d   = win_dur;
        end
      end
      StRun: begin
        // Abort beats completion; completion does not wait for tick.
        if (!req[own_q]) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (rem_q == '0) begin
          state_d = StDone;
        end else if (tick) begin
          rem_d = rem_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        rem_d   = '0;
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
      end
    endcase

    own_onehot = N'(1) << own_d;
    gnt_d      = (state_d == StRun)  ? own_onehot : '0;
    done_d     = (state_d == StDone) ? own_onehot : '0;
    busy_d     = (state_d != StIdle);
  end

  // State and output registers; reset leaves channel 0 first in line.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      ptr_q   <= IW'(N - 1);
      own_q   <= '0;
      rem_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;

endmodule
